morse_key_classifier: RTL and testbench
=======================================

Name: morse_key_classifier

Overview:
- Upstream input stage of the Morse path. Converts one raw straight-key signal into the four single-cycle symbol strobes that the transmit FSM consumes: dot, dash, character space and word space.
- Contains a synchronizer, a debouncer and a timing state machine.
- Classifies each symbol by the measured key-down duration and key-up gap, both expressed in Morse units.

Parameters:
- UNIT_CYCLES, 1000: clock cycles per Morse unit (one dot length).
- DEBOUNCE_CYCLES, 8: consecutive stable cycles required before the debounced level changes.
- CNT_W, 16: width of the duration/gap counters. Must hold 5*UNIT_CYCLES.

Ports:
- clk  in  1: system clock; single clock domain.
- rst  in  1: asynchronous, active-low reset.
- key_in  in  1: raw key, active-high (1 = pressed), asynchronous to clk.
- dot_inp  out  1: one-cycle strobe, dot detected.
- dash_inp  out  1: one-cycle strobe, dash detected.
- char_space_inp  out  1: one-cycle strobe, inter-character gap detected.
- word_space_inp  out  1: one-cycle strobe, inter-word gap detected.
- key_state  out  1: debounced key level, for an indicator LED.

Behaviour:
- Reset (rst=0, asynchronous):
  - All strobes = 0; key_state = 0.
  - Synchronizer flops = 0; all counters = 0; FSM = IDLE.
  - Recovery is synchronous to clk.
- Synchronizer: 2 flops on key_in. Only the second flop's output (key_sync) feeds the logic.
- Debounce:
  - db_cnt increments while key_sync != key_state, and clears to 0 when they are equal.
  - When db_cnt reaches DEBOUNCE_CYCLES-1 with a mismatch still present, key_state toggles and db_cnt clears.
  - Any pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edges: rise = key_state 0->1 and fall = key_state 1->0, both taken from a registered copy of key_state.
- FSM states:
  - IDLE: key up, no symbol pending.
    - rise -> MARK with mark_cnt = 1.
  - MARK: key down. mark_cnt increments each cycle and saturates at 2^CNT_W-1.
    - On fall: if mark_cnt < 2*UNIT_CYCLES, pulse dot_inp; otherwise pulse dash_inp.
    - Then go to GAP with gap_cnt = 1 and space_sent = 0.
  - GAP: key up. gap_cnt increments each cycle.
    - When gap_cnt == 2*UNIT_CYCLES: pulse char_space_inp and set space_sent = 1.
    - When gap_cnt == 5*UNIT_CYCLES: pulse word_space_inp and go to IDLE. No second char_space is issued.
    - rise before 2*UNIT_CYCLES (intra-character gap): go to MARK, mark_cnt = 1, no strobe.
    - rise between 2 and 5 units: go to MARK; the char_space already issued stands.
- Strobes:
  - All strobes are registered outputs, high for exactly one cycle.
  - They are mutually exclusive; at most one is high in any cycle.
  - Strobe latency: asserted in the cycle after the key_state edge (or the counter match) that triggers it.
  - End-to-end latency from a stable raw release to dot/dash: 2 (sync) + DEBOUNCE_CYCLES + 2 cycles.
- Simultaneous events:
  - A rise in the same cycle that gap_cnt matches a threshold: the rise takes priority, the FSM goes to MARK, and that threshold strobe is suppressed.
- Reset mid-operation: abandons any pending symbol with no strobe. A key held through reset release is seen as a new rise once debounced.
- Saturation: a held key saturates mark_cnt and still yields a dash on release. gap_cnt never exceeds 5*UNIT_CYCLES because GAP exits at that value.
- No word_space is emitted from IDLE; a long idle gap produces exactly one word_space.

Test Plan:
- Bench parameters for all scenarios: UNIT_CYCLES=10, DEBOUNCE_CYCLES=4.
- Reset then key held 50 cycles -> key_state=0, all strobes=0 for the entire reset duration and afterwards until debounce completes.
- Stable press of 5 cycles, then release held -> exactly one dot_inp pulse, char_space_inp at gap cycle 20, word_space_inp at gap cycle 50, no further strobes.
- Debounced press of 19 cycles -> dot_inp. Debounced press of 20 cycles -> dash_inp. Press of 300 cycles -> dash_inp.
- Glitch: key_in high for 3 cycles -> key_state stays 0, no strobes.
- Glitch: key_in bounces 0/1 for 10 cycles before settling -> single rise, single symbol.
- Dot, gap of 15 cycles, dash -> dot_inp then dash_inp, no char_space_inp.
- Dot, gap of 30 cycles, dot -> dot_inp, char_space_inp, dot_inp, no word_space_inp before the second dot.
- rst asserted mid-MARK (after 8 key-down cycles) -> all outputs 0 immediately. Key released after rst deasserts -> no strobe. Next full press classifies normally.

Source files
------------

// File: rtl/morse_key_classifier.sv
// Straight-key front end: synchronizes and debounces a raw key, then times marks and gaps
// to emit one-cycle dot, dash, character-space and word-space strobes.
module morse_key_classifier #(
  parameter int unsigned UNIT_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic dot_inp,
  output logic dash_inp,
  output logic char_space_inp,
  output logic word_space_inp,
  output logic key_state
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TwoUnits  = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] FiveUnits = CNT_W'(5 * UNIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StMark, StGap} state_e;

  logic             sync1_q, sync2_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic             key_state_q, key_state_d;
  logic             key_dly_q;
  logic             rise_q, rise_d, fall_q, fall_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             space_sent_q, space_sent_d;
  logic             dot_q, dot_d, dash_q, dash_d;
  logic             char_q, char_d, word_q, word_d;

  // Debounce: the level only follows key_sync after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    db_cnt_d    = '0;
    key_state_d = key_state_q;
    if (sync2_q != key_state_q) begin
      if (db_cnt_q == DbLast) begin
        key_state_d = ~key_state_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
    rise_d = key_state_q & ~key_dly_q;
    fall_d = ~key_state_q & key_dly_q;
  end

  always_comb begin
    state_d      = state_q;
    mark_cnt_d   = mark_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    space_sent_d = space_sent_q;
    dot_d        = 1'b0;
    dash_d       = 1'b0;
    char_d       = 1'b0;
    word_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise_q) begin
          state_d    = StMark;
          mark_cnt_d = CNT_W'(1);
        end
      end
      StMark: begin
        if (fall_q) begin
          if (mark_cnt_q < TwoUnits) begin
            dot_d = 1'b1;
          end else begin
            dash_d = 1'b1;
          end
          state_d      = StGap;
          gap_cnt_d    = CNT_W'(1);
          space_sent_d = 1'b0;
        end else if (mark_cnt_q != '1) begin
          mark_cnt_d = mark_cnt_q + CNT_W'(1);
        end
      end
      StGap: begin
        // A rise wins over a coincident threshold match and suppresses its strobe.
        if (rise_q) begin
          state_d    = StMark;
          mark_cnt_d = CNT_W'(1);
        end else if (gap_cnt_q == FiveUnits) begin
          word_d  = 1'b1;
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
          if (gap_cnt_q == TwoUnits && !space_sent_q) begin
            char_d       = 1'b1;
            space_sent_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      key_state_q  <= 1'b0;
      key_dly_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      state_q      <= StIdle;
      mark_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      space_sent_q <= 1'b0;
      dot_q        <= 1'b0;
      dash_q       <= 1'b0;
      char_q       <= 1'b0;
      word_q       <= 1'b0;
    end else begin
      sync1_q      <= key_in;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      key_state_q  <= key_state_d;
      key_dly_q    <= key_state_q;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      mark_cnt_q   <= mark_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      space_sent_q <= space_sent_d;
      dot_q        <= dot_d;
      dash_q       <= dash_d;
      char_q       <= char_d;
      word_q       <= word_d;
    end
  end

  assign dot_inp        = dot_q;
  assign dash_inp       = dash_q;
  assign char_space_inp = char_q;
  assign word_space_inp = word_q;
  assign key_state      = key_state_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Randomized and directed bench for morse_key_classifier; expected strobes come from a
// run-length model of the raw key waveform.
module tb_morse_key_classifier;

  localparam int Unit = 10;
  localparam int Db   = 4;
  localparam int Cw   = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_in = 1'b0;
  logic dot_inp, dash_inp, char_space_inp, word_space_inp, key_state;

  int checks = 0;
  int failures = 0;

  bit raw_q[$];
  bit exp_ks[];
  int exp_code[];

  morse_key_classifier #(
    .UNIT_CYCLES    (Unit),
    .DEBOUNCE_CYCLES(Db),
    .CNT_W          (Cw)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .key_in        (key_in),
    .dot_inp       (dot_inp),
    .dash_inp      (dash_inp),
    .char_space_inp(char_space_inp),
    .word_space_inp(word_space_inp),
    .key_state     (key_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, want);
    end
  endtask

  function automatic void add(input bit v, input int n);
    for (int i = 0; i < n; i++) raw_q.push_back(v);
  endfunction

  // Strobe codes: 0 none, 1 dot, 2 dash, 3 char space, 4 word space.
  function automatic void model();
    int L = raw_q.size();
    int sync[];
    int tog[$];
    int st = 0;
    int t = 0;
    int lvl = 0;
    int k = 0;
    sync = new[L];
    exp_ks = new[L];
    exp_code = new[L];
    for (int i = 0; i < L; i++) begin
      sync[i] = (i >= 2) ? int'(raw_q[i-2]) : 0;
      exp_code[i] = 0;
    end
    // The debounced level flips Db cycles into any run of Db or more disagreeing samples.
    while (t < L) begin
      if (sync[t] != st) begin
        int r = 0;
        while (t + r < L && sync[t+r] == sync[t]) r++;
        if (r >= Db) begin
          tog.push_back(t + Db);
          st = 1 - st;
          t += Db;
        end else begin
          t += r;
        end
      end else begin
        t++;
      end
    end
    for (int i = 0; i < L; i++) begin
      while (k < tog.size() && tog[k] <= i) begin
        lvl = 1 - lvl;
        k++;
      end
      exp_ks[i] = bit'(lvl);
    end
    for (int i = 1; i < tog.size(); i += 2) begin
      int tf = tog[i];
      int n = tf - tog[i-1];
      int g = (i + 1 < tog.size()) ? tog[i+1] - tf : 1000000;
      if (tf + 2 < L) exp_code[tf+2] = (n < 2 * Unit) ? 1 : 2;
      if (g > 2 * Unit && tf + 2 * Unit + 2 < L) exp_code[tf+2*Unit+2] = 3;
      if (g > 5 * Unit && tf + 5 * Unit + 2 < L) exp_code[tf+5*Unit+2] = 4;
    end
  endfunction

  task automatic run_scen(input string name, input bit pre_key, input int rst_cycles);
    int L;
    int obs;
    model();
    L = raw_q.size();
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_in = pre_key;
    #1;
    check({name, "/rst_async"},
          {key_state, dot_inp, dash_inp, char_space_inp, word_space_inp}, 0);
    for (int i = 0; i < rst_cycles; i++) begin
      @(negedge clk);
      check({name, "/rst_hold"},
            {key_state, dot_inp, dash_inp, char_space_inp, word_space_inp}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int t = 0; t < L; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      key_in = raw_q[t];
      @(negedge clk);
      obs = dot_inp ? 1 : dash_inp ? 2 : char_space_inp ? 3 : word_space_inp ? 4 : 0;
      check({name, "/key_state"}, key_state, exp_ks[t]);
      check({name, "/strobe"}, obs, exp_code[t]);
      check({name, "/exclusive"},
            ($countones({dot_inp, dash_inp, char_space_inp, word_space_inp}) <= 1), 1);
    end
    raw_q.delete();
  endtask

  initial begin
    // Key held through a long reset, then a 30-cycle press.
    add(1, 30); add(0, 80);
    run_scen("reset_hold", 1'b1, 50);

    // Clean dot followed by a full idle gap.
    add(0, 3); add(1, 5); add(0, 70);
    run_scen("dot_idle", 1'b0, 2);

    // Dot/dash boundary and a saturating long press.
    add(0, 3); add(1, 19); add(0, 60); add(1, 20); add(0, 60); add(1, 300); add(0, 70);
    run_scen("dot_dash_bound", 1'b0, 2);

    add(0, 3); add(1, 3); add(0, 60);
    run_scen("glitch", 1'b0, 2);

    // Bounce with runs never reaching the debounce length, then settle high.
    add(0, 3);
    begin
      bit v = 1'b1;
      int n = 0;
      while (n < 10) begin
        int r = $urandom_range(1, 3);
        add(v, r);
        n += r;
        v = ~v;
      end
    end
    add(1, 12); add(0, 70);
    run_scen("bounce", 1'b0, 2);

    add(0, 3); add(1, 6); add(0, 15); add(1, 25); add(0, 70);
    run_scen("dot_gap15_dash", 1'b0, 2);

    add(0, 3); add(1, 6); add(0, 30); add(1, 6); add(0, 70);
    run_scen("dot_gap30_dot", 1'b0, 2);

    // Gap thresholds: ties with a rise suppress the strobe.
    add(0, 3); add(1, 6); add(0, 20); add(1, 6); add(0, 21); add(1, 6);
    add(0, 50); add(1, 6); add(0, 51); add(1, 6); add(0, 70);
    run_scen("gap_bounds", 1'b0, 2);

    // Stop mid-mark; the next scenario resets with the key still held.
    add(0, 2); add(1, 14);
    run_scen("pre_mid_mark", 1'b0, 2);
    add(1, 1); add(0, 60); add(1, 25); add(0, 70);
    run_scen("rst_mid_mark", 1'b1, 3);

    for (int s = 0; s < 3; s++) begin
      bit v = 1'b0;
      add(0, 3);
      for (int j = 0; j < 15; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int b = 0; b < 6; b++) add(bit'($urandom_range(0, 1)), $urandom_range(1, 4));
        end
        v = ~v;
        add(v, v ? $urandom_range(1, 40) : $urandom_range(1, 70));
      end
      add(0, 80);
      run_scen($sformatf("random%0d", s), 1'b0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
